// File: rtl/alu_mul_seq_pkg.sv
// Shared encodings for the multiply sequencer and the execute-stage ALU controls.
package alu_mul_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABS_A  = 3'd1,
    ABS_B  = 3'd2,
    ITER   = 3'd3,
    NEG_LO = 3'd4,
    NEG_HI = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_CMP = 3'b110;

  localparam logic ADD_SEL_ADD = 1'b0;
  localparam logic ADD_SEL_SUB = 1'b1;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add 32x32->64 multiplier that borrows the shared ALU for every add/negate.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_add_sel,
  output logic [2:0]       alu_sel,
  output logic             alu_arith_sel,
  output logic [2:0]       alu_comp_sel,
  output logic             alu_sign,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_cflag,
  input  logic             alu_zero
);

  state_t           state, state_n;
  logic [WIDTH-1:0] mcand, mcand_n;
  logic [WIDTH-1:0] acc_hi, acc_hi_n;
  logic [WIDTH-1:0] acc_lo, acc_lo_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             neg_res, neg_res_n;
  logic             sgn, sgn_n;
  logic             lo_zero, lo_zero_n;
  logic [WIDTH-1:0] alu_a_n, alu_b_n;
  logic             alu_add_sel_n;
  logic [2:0]       alu_sel_n;

  assign alu_arith_sel = 1'b0;
  assign alu_comp_sel  = 3'b000;
  assign alu_sign      = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mcand       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      cnt         <= '0;
      neg_res     <= 1'b0;
      sgn         <= 1'b0;
      lo_zero     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      prod_hi     <= '0;
      prod_lo     <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_add_sel <= 1'b0;
      alu_sel     <= 3'b000;
    end else begin
      state       <= state_n;
      mcand       <= mcand_n;
      acc_hi      <= acc_hi_n;
      acc_lo      <= acc_lo_n;
      cnt         <= cnt_n;
      neg_res     <= neg_res_n;
      sgn         <= sgn_n;
      lo_zero     <= lo_zero_n;
      busy        <= (state_n != IDLE);
      done        <= (state_n == DONE);
      alu_a       <= alu_a_n;
      alu_b       <= alu_b_n;
      alu_add_sel <= alu_add_sel_n;
      alu_sel     <= alu_sel_n;
      if (state_n == DONE) begin
        prod_hi <= acc_hi_n;
        prod_lo <= acc_lo_n;
      end
    end
  end

  always_comb begin
    state_n       = state;
    mcand_n       = mcand;
    acc_hi_n      = acc_hi;
    acc_lo_n      = acc_lo;
    cnt_n         = cnt;
    neg_res_n     = neg_res;
    sgn_n         = sgn;
    lo_zero_n     = lo_zero;
    alu_a_n       = '0;
    alu_b_n       = '0;
    alu_add_sel_n = ADD_SEL_ADD;
    alu_sel_n     = ALU_ADD;

    unique case (state)
      IDLE: begin
        if (start) begin
          mcand_n   = op_a;
          acc_lo_n  = op_b;
          acc_hi_n  = '0;
          cnt_n     = '0;
          sgn_n     = signed_op;
          lo_zero_n = 1'b0;
          neg_res_n = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          state_n   = signed_op ? ABS_A : ITER;
        end
      end
      ABS_A: begin
        if (mcand[WIDTH-1]) mcand_n = alu_z;
        state_n = ABS_B;
      end
      ABS_B: begin
        // 0x80000000 negates to itself, which is already its unsigned magnitude
        if (acc_lo[WIDTH-1]) acc_lo_n = alu_z;
        state_n = ITER;
      end
      ITER: begin
        if (acc_lo[0]) begin
          acc_hi_n = {alu_cflag, alu_z[WIDTH-1:1]};
          acc_lo_n = {alu_z[0], acc_lo[WIDTH-1:1]};
        end else begin
          acc_hi_n = {1'b0, acc_hi[WIDTH-1:1]};
          acc_lo_n = {acc_hi[0], acc_lo[WIDTH-1:1]};
        end
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) state_n = sgn ? NEG_LO : DONE;
      end
      NEG_LO: begin
        if (neg_res) begin
          acc_lo_n  = alu_z;
          lo_zero_n = alu_zero;
        end
        state_n = NEG_HI;
      end
      NEG_HI: begin
        if (neg_res) acc_hi_n = alu_z;
        state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // ALU controls are registered, so they are set up for the state being entered
    unique case (state_n)
      ABS_A: begin
        alu_b_n       = mcand_n;
        alu_add_sel_n = ADD_SEL_SUB;
      end
      ABS_B, NEG_LO: begin
        alu_b_n       = acc_lo_n;
        alu_add_sel_n = ADD_SEL_SUB;
      end
      ITER: begin
        alu_a_n = acc_hi_n;
        alu_b_n = mcand_n;
      end
      NEG_HI: begin
        // two's-complement high word borrows only when the low word negated to zero
        if (lo_zero_n) begin
          alu_b_n       = acc_hi_n;
          alu_add_sel_n = ADD_SEL_SUB;
        end else begin
          alu_a_n   = acc_hi_n;
          alu_b_n   = '1;
          alu_sel_n = ALU_XOR;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural shared ALU on the alu_* ports.
module tb_alu_mul_seq;

  logic        clk, rst, start, signed_op;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] prod_hi, prod_lo, alu_a, alu_b, alu_z;
  logic        alu_add_sel, alu_arith_sel, alu_sign, alu_cflag, alu_zero;
  logic [2:0]  alu_sel, alu_comp_sel;
  logic [32:0] alu_sum;

  int n_cmp = 0;
  int n_err = 0;

  alu_mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .prod_hi(prod_hi), .prod_lo(prod_lo), .alu_a(alu_a), .alu_b(alu_b),
    .alu_add_sel(alu_add_sel), .alu_sel(alu_sel), .alu_arith_sel(alu_arith_sel),
    .alu_comp_sel(alu_comp_sel), .alu_sign(alu_sign), .alu_z(alu_z),
    .alu_cflag(alu_cflag), .alu_zero(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: add/sub with carry-out, xor
  always_comb begin
    alu_sum   = '0;
    alu_z     = '0;
    alu_cflag = 1'b0;
    case (alu_sel)
      3'b000: begin
        alu_sum   = alu_add_sel ? ({1'b0, alu_a} - {1'b0, alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});
        alu_z     = alu_sum[31:0];
        alu_cflag = alu_sum[32];
      end
      3'b011:  alu_z = alu_a ^ alu_b;
      default: ;
    endcase
    alu_zero = (alu_z == 32'd0);
  end

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Start accepted at the edge ending cycle 0; returns cycle of done (or -1 on timeout)
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] hi, output logic [31:0] lo,
                        output int bcnt);
    signed_op = s; op_a = a; op_b = b; start = 1'b1;
    tick();
    start = 1'b0; signed_op = ~s; op_a = ~a; op_b = ~b;
    lat = -1; bcnt = 0; hi = '0; lo = '0;
    for (int c = 1; c <= 60; c++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = c; hi = prod_hi; lo = prod_lo;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int          lat, bcnt, c_done;
    logic [31:0] hi, lo;
    logic        seen_done;

    vecs[0] = '{1'b0, 32'd3,        32'd5,        32'h00000000, 32'h0000000F, 33};
    vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[2] = '{1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 37};
    vecs[3] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 37};
    vecs[4] = '{1'b1, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 37};
    vecs[5] = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 33};
    vecs[6] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 37};
    vecs[7] = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 37};
    vecs[8] = '{1'b1, 32'd0,        32'hFFFFFFFB, 32'h00000000, 32'h00000000, 37};
    vecs[9] = '{1'b1, 32'hFFFF0000, 32'h00010000, 32'hFFFFFFFF, 32'h00000000, 37};

    rst = 1'b1; start = 1'b0; signed_op = 1'b0; op_a = '0; op_b = '0;
    tick(); tick();
    chk("reset_outputs", {31'd0, busy, done, prod_hi, prod_lo} , 64'd0);
    chk("reset_alu", {alu_a, alu_b}, 64'd0);
    chk("reset_alu_ctl", {59'd0, alu_add_sel, alu_sel, 1'b0}, 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, hi, lo, bcnt);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_prod_hi", i), {32'd0, hi}, {32'd0, vecs[i].hi});
      chk($sformatf("v%0d_prod_lo", i), {32'd0, lo}, {32'd0, vecs[i].lo});
      chk($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'(vecs[i].lat));
      chk($sformatf("v%0d_tied_ctl", i), {57'd0, alu_arith_sel, alu_comp_sel, alu_sign}, 64'd0);
      tick();
      chk($sformatf("v%0d_after_done", i), {62'd0, busy, done}, 64'd0);
      chk($sformatf("v%0d_prod_hold", i), {prod_hi, prod_lo}, {vecs[i].hi, vecs[i].lo});
    end

    // start during DONE is ignored; start in the following IDLE cycle is accepted
    signed_op = 1'b0; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (32) tick();
    chk("dstart_done_c33", {63'd0, done}, 64'd1);
    op_a = 32'd2; op_b = 32'd2; start = 1'b1;
    tick();
    chk("dstart_ignored", {62'd0, busy, done}, 64'd0);
    tick();
    start = 1'b0;
    chk("dstart_accepted", {63'd0, busy}, 64'd1);
    c_done = -1;
    for (int c = 35; c <= 80; c++) begin
      if (done) begin c_done = c; break; end
      tick();
    end
    chk("dstart_latency", 64'(c_done), 64'd67);
    chk("dstart_prod", {prod_hi, prod_lo}, 64'd4);
    tick();

    // reset mid-operation aborts without done; a stray start is ignored
    signed_op = 1'b0; op_a = 32'd7; op_b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    seen_done = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done) seen_done = 1'b1;
      if (c == 10) begin start = 1'b1; op_a = 32'd2; op_b = 32'd2; end
      if (c == 11) begin
        start = 1'b0;
        chk("midstart_ignored_mcand", {32'd0, alu_b}, 64'd7);
      end
      if (c == 20) rst = 1'b1;
      if (c == 21) begin
        chk("midrst_outputs", {30'd0, busy, done, alu_add_sel, 1'b0}, 64'd0);
        chk("midrst_prod", {prod_hi, prod_lo}, 64'd0);
        chk("midrst_alu", {alu_a, alu_b}, 64'd0);
        chk("midrst_alu_sel", {61'd0, alu_sel}, 64'd0);
      end
      if (c == 22) rst = 1'b0;
      tick();
    end
    chk("midrst_no_done", {63'd0, seen_done}, 64'd0);
    chk("midrst_idle", {63'd0, busy}, 64'd0);

    run_op(1'b0, 32'd6, 32'd7, lat, hi, lo, bcnt);
    chk("after_rst_latency", 64'(lat), 64'd33);
    chk("after_rst_prod", {hi, lo}, 64'd42);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
